// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier family: FSM state encoding,
// radix-4 Booth digit codes and the digit-to-selection decode.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth digit codes as seen in Q[2:0] (bit 0 is the bit shifted out last)
    localparam logic [2:0] DIG_ZERO_0 = 3'b000;
    localparam logic [2:0] DIG_POS1_A = 3'b001;
    localparam logic [2:0] DIG_POS1_B = 3'b010;
    localparam logic [2:0] DIG_POS2   = 3'b011;
    localparam logic [2:0] DIG_NEG2   = 3'b100;
    localparam logic [2:0] DIG_NEG1_A = 3'b101;
    localparam logic [2:0] DIG_NEG1_B = 3'b110;
    localparam logic [2:0] DIG_ZERO_1 = 3'b111;

    // Returns {neg, two, zero}: negate the term, use 2M instead of M, term is 0
    function automatic logic [2:0] booth_sel(input logic [2:0] code);
        logic [2:0] sel;
        case (code)
            DIG_ZERO_0, DIG_ZERO_1: sel = 3'b001;
            DIG_POS1_A, DIG_POS1_B: sel = 3'b000;
            DIG_POS2:               sel = 3'b010;
            DIG_NEG2:               sel = 3'b110;
            default:                sel = 3'b100;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Combinational radix-4 Booth term generator: maps a 3-bit digit code and the
// current multiplicand onto the signed partial-product term 0, +-M or +-2M.
module booth_digit_sel
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         code,
    input  logic [2*WIDTH+1:0] m,
    output logic [2*WIDTH+1:0] term
);

    logic [2:0]         sel;
    logic [2*WIDTH+1:0] mag;

    // Decode the digit, pick M or 2M, then apply sign / zero
    always_comb begin
        sel = booth_sel(code);
        mag = sel[1] ? {m[2*WIDTH:0], 1'b0} : m;
        if (sel[0]) begin
            term = '0;
        end else if (sel[2]) begin
            term = -mag;
        end else begin
            term = mag;
        end
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per clock, start/done handshake.
// Optional macro BOOTH_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all equal (every remaining digit is zero).
module booth_seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int NDIG = WIDTH / 2 + 1;
    localparam int AW   = 2 * WIDTH + 2;
    localparam int QW   = WIDTH + 3;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG);

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("booth_seq_mult: WIDTH must be even and >= 4");
    end

    state_t             state_reg;
    logic [AW-1:0]      m_reg;
    logic [QW-1:0]      q_reg;
    logic [AW-1:0]      acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [2*WIDTH-1:0] product_reg;

    logic               ext_a;
    logic               ext_b;
    logic [AW-1:0]      m_load;
    logic [QW-1:0]      q_load;
    logic [AW-1:0]      term;
    logic [AW-1:0]      acc_next;
    logic [QW-1:0]      q_next;
    logic               run_finish;

    // Extension bit is the operand MSB in signed mode, zero otherwise
    assign ext_a = signed_mode & a[WIDTH-1];
    assign ext_b = signed_mode & b[WIDTH-1];

    assign m_load[WIDTH-1:0] = a;
    assign q_load[WIDTH:1]   = b;
    assign q_load[0]         = 1'b0;

    genvar gi;
    for (gi = WIDTH; gi < AW; gi++) begin : g_ext_m
        assign m_load[gi] = ext_a;
    end
    for (gi = WIDTH + 1; gi < QW; gi++) begin : g_ext_q
        assign q_load[gi] = ext_b;
    end

    booth_digit_sel #(
        .WIDTH (WIDTH)
    ) u_digit_sel (
        .code  (q_reg[2:0]),
        .m     (m_reg),
        .term  (term)
    );

    assign acc_next = acc_reg + term;
    assign q_next   = {{2{q_reg[QW-1]}}, q_reg[QW-1:2]};

`ifdef BOOTH_EARLY_TERM_EN
    // All-equal Q means only 000/111 codes remain, so nothing more to add
    assign run_finish = (cnt_reg == CNT_LAST) || (&q_reg) || ~(|q_reg);
`else
    assign run_finish = (cnt_reg == CNT_LAST);
`endif

    // Control FSM and datapath registers; outputs are registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            m_reg       <= '0;
            q_reg       <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        m_reg     <= m_load;
                        q_reg     <= q_load;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    if (run_finish) begin
                        product_reg <= acc_reg[2*WIDTH-1:0];
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        acc_reg <= acc_next;
                        m_reg   <= {m_reg[AW-3:0], 2'b00};
                        q_reg   <= q_next;
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and random bench for booth_seq_mult at WIDTH=32 and WIDTH=8,
// with a queue scoreboard filled on each accepted start.
module tb_booth_seq_mult;

`ifdef BOOTH_EARLY_TERM_EN
    localparam int LAT_NEG7X3 = 3;
    localparam int LAT_B4     = 3;
`else
    localparam int LAT_NEG7X3 = 18;
    localparam int LAT_B4     = 18;
`endif
    localparam int BUDGET = 40;

    logic        clock = 1'b0;
    logic        reset;

    logic        start32, sm32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] prod32;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb32[$];
    logic [15:0] sb8[$];

    booth_seq_mult #(.WIDTH(32)) dut32 (
        .clock       (clock),
        .reset       (reset),
        .start       (start32),
        .signed_mode (sm32),
        .a           (a32),
        .b           (b32),
        .busy        (busy32),
        .done        (done32),
        .product     (prod32)
    );

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .product     (prod8)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref32(input logic sm, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe, ye;
        xe = sm ? {{32{x[31]}}, x} : {32'd0, x};
        ye = sm ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    function automatic logic [15:0] ref8(input logic sm, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] xe, ye;
        xe = sm ? {{8{x[7]}}, x} : {8'd0, x};
        ye = sm ? {{8{y[7]}}, y} : {8'd0, y};
        return xe * ye;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a one-cycle start on the 32-bit DUT and record the expected product
    task automatic start_op32(input logic sm, input logic [31:0] x, input logic [31:0] y, input bit hold);
        start32 = 1'b1;
        sm32    = sm;
        a32     = x;
        b32     = y;
        sb32.push_back(ref32(sm, x, y));
        tick();
        start32 = hold;
        sm32    = ~sm;
        a32     = $urandom;
        b32     = $urandom;
    endtask

    // Wait (bounded) for done on the 32-bit DUT and score the product
    task automatic wait_done32(input string tag, output int lat);
        logic [63:0] exp;
        lat = 0;
        while (done32 !== 1'b1 && lat < BUDGET) begin
            tick();
            lat++;
        end
        if (done32 !== 1'b1) begin
            check({tag, "_timeout"}, {63'd0, done32}, 64'd1);
        end else begin
            exp = (sb32.size() != 0) ? sb32.pop_front() : 'x;
            check({tag, "_product"}, prod32, exp);
            check({tag, "_busy_at_done"}, {63'd0, busy32}, 64'd0);
            $display("op %s: product=%h expected=%h latency=%0d", tag, prod32, exp, lat);
        end
    endtask

    initial begin
        int          lat;
        int          ndone;
        bit          got32, got8;
        logic        sm;
        logic [31:0] x32, y32;
        logic [7:0]  x8, y8;
        logic [63:0] exp32, held;
        logic [15:0] exp8;

        reset   = 1'b1;
        start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy32", {63'd0, busy32}, 64'd0);
        check("rst_done32", {63'd0, done32}, 64'd0);
        check("rst_prod32", prod32, 64'd0);
        check("rst_prod8",  {48'd0, prod8}, 64'd0);

        // Signed -7 * 3, with latency and busy during RUN
        start_op32(1'b1, 32'hFFFF_FFF9, 32'd3, 1'b0);
        check("neg7x3_busy", {63'd0, busy32}, 64'd1);
        check("neg7x3_nodone", {63'd0, done32}, 64'd0);
        wait_done32("neg7x3", lat);
        check("neg7x3_const", prod32, 64'hFFFF_FFFF_FFFF_FFEB);
        check("neg7x3_latency", 64'(lat), 64'(LAT_NEG7X3));

        // Mode difference and corner operands
        start_op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done32("ones_unsigned", lat);
        check("ones_unsigned_const", prod32, 64'hFFFF_FFFE_0000_0001);
        start_op32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done32("ones_signed", lat);
        check("ones_signed_const", prod32, 64'h0000_0000_0000_0001);
        start_op32(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done32("minneg_sq", lat);
        check("minneg_sq_const", prod32, 64'h4000_0000_0000_0000);
        start_op32(1'b0, 32'h8000_0000, 32'h0000_0002, 1'b0);
        wait_done32("msb_x2", lat);
        check("msb_x2_const", prod32, 64'h0000_0001_0000_0000);

        // Start at RUN cycle 5 is ignored; result then held
        start_op32(1'b1, 32'hDEAD_BEEF, 32'h1234_5679, 1'b0);
        repeat (4) tick();
        start32 = 1'b1; sm32 = 1'b0; a32 = 32'd1; b32 = 32'd1;
        tick();
        start32 = 1'b0;
        wait_done32("ignore_start", lat);
        held = ref32(1'b1, 32'hDEAD_BEEF, 32'h1234_5679);
        repeat (3) tick();
        check("hold_product", prod32, held);
        check("hold_idle_busy", {63'd0, busy32}, 64'd0);
        check("hold_idle_done", {63'd0, done32}, 64'd0);

        // Start held across DONE: second op enters RUN with no IDLE cycle
        start_op32(1'b1, 32'h0000_0101, 32'hFFFF_8001, 1'b1);
        start32 = 1'b1; sm32 = 1'b1; a32 = 32'hFFFF_FFFB; b32 = 32'd4;
        sb32.push_back(ref32(1'b1, 32'hFFFF_FFFB, 32'd4));
        wait_done32("b2b_first", lat);
        tick();
        start32 = 1'b0;
        check("b2b_busy", {63'd0, busy32}, 64'd1);
        check("b2b_done_low", {63'd0, done32}, 64'd0);
        wait_done32("b2b_second", lat);
        check("b2b_second_latency", 64'(lat), 64'(LAT_B4));

        // Reset at RUN cycle 8 aborts the operation
        start_op32(1'b0, 32'hDEAD_BEEF, 32'h1234_5679, 1'b0);
        void'(sb32.pop_back());
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {63'd0, busy32}, 64'd0);
        check("abort_done", {63'd0, done32}, 64'd0);
        check("abort_prod", prod32, 64'd0);
        ndone = 0;
        repeat (25) begin
            tick();
            if (done32 === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        $display("op abort: busy=%b done=%b product=%h", busy32, done32, prod32);

        // Random operands on both widths, run side by side
        for (int i = 0; i < 1500; i++) begin
            sm  = 1'($urandom_range(0, 1));
            x32 = (i % 16 == 0) ? 32'h8000_0000 : $urandom;
            y32 = (i % 16 == 1) ? 32'hFFFF_FFFF : $urandom;
            x8  = (i % 8 == 0) ? 8'h80 : 8'($urandom);
            y8  = (i % 8 == 3) ? 8'h7F : 8'($urandom);
            start32 = 1'b1; sm32 = sm; a32 = x32; b32 = y32;
            start8  = 1'b1; sm8 = ~sm; a8 = x8; b8 = y8;
            sb32.push_back(ref32(sm, x32, y32));
            sb8.push_back(ref8(~sm, x8, y8));
            tick();
            start32 = 1'b0;
            start8  = 1'b0;
            got32 = 1'b0;
            got8  = 1'b0;
            lat   = 0;
            while (!(got32 && got8) && lat < BUDGET) begin
                tick();
                lat++;
                if (done8 === 1'b1 && !got8) begin
                    got8 = 1'b1;
                    exp8 = (sb8.size() != 0) ? sb8.pop_front() : 'x;
                    check("rnd8_product", {48'd0, prod8}, {48'd0, exp8});
                end
                if (done32 === 1'b1 && !got32) begin
                    got32 = 1'b1;
                    exp32 = (sb32.size() != 0) ? sb32.pop_front() : 'x;
                    check("rnd32_product", prod32, exp32);
                end
            end
            if (!got8)  check("rnd8_timeout",  {63'd0, done8},  64'd1);
            if (!got32) check("rnd32_timeout", {63'd0, done32}, 64'd1);
            $display("rnd %0d: sm=%b a32=%h b32=%h p32=%h | a8=%h b8=%h p8=%h",
                     i, sm, x32, y32, prod32, x8, y8, prod8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
